// File: rtl/mp_pkg.sv
// Shared types and default sizes for the mp request/response interface between
// the traffic-generator cores and the shared-memory responder.
package mp_pkg;

    localparam int MP_NUM_CORES = 3;
    localparam int MP_ADDR_W    = 8;
    localparam int MP_DATA_W    = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mp_state_e;

    typedef struct packed {
        logic                 we;
        logic [MP_ADDR_W-1:0] addr;
        logic [MP_DATA_W-1:0] wdata;
    } mp_req_t;

endpackage

// File: rtl/mp_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after
// ptr, searching with wrap-around, and only while enable is high.
module mp_rr_arbiter #(
    parameter int N = 3,
    localparam int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    input  logic             enable,
    output logic [N-1:0]     gnt,
    output logic [PTR_W-1:0] gnt_idx,
    output logic             gnt_valid
);

    logic [PTR_W-1:0] idx;

    always_comb begin
        gnt       = '0;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        idx       = '0;
        for (int i = 0; i < N; i++) begin
            idx = PTR_W'((32'(ptr) + 32'(i)) % N);
            if (enable && !gnt_valid && req[idx]) begin
                gnt_valid = 1'b1;
                gnt[idx]  = 1'b1;
                gnt_idx   = idx;
            end
        end
    end

endmodule

// File: rtl/mp_mem_responder.sv
// Shared-memory responder: round-robin accepts one load/store at a time and
// returns a one-cycle response to the originating core after LATENCY waits.
module mp_mem_responder #(
    parameter int NUM_CORES = mp_pkg::MP_NUM_CORES,
    parameter int ADDR_W    = mp_pkg::MP_ADDR_W,
    parameter int DATA_W    = mp_pkg::MP_DATA_W,
    parameter int DEPTH     = 256,
    parameter int LATENCY   = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_CORES-1:0]        req_valid,
    output logic [NUM_CORES-1:0]        req_ready,
    input  logic [NUM_CORES-1:0]        req_we,
    input  logic [NUM_CORES*ADDR_W-1:0] req_addr,
    input  logic [NUM_CORES*DATA_W-1:0] req_wdata,
    output logic [NUM_CORES-1:0]        rsp_valid,
    output logic                        rsp_err,
    output logic [DATA_W-1:0]           rsp_rdata,
    output logic                        busy
);

    import mp_pkg::*;

    localparam int ID_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    mp_state_e             state_q, state_d;
    logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]       id_q, id_d;
    logic [2:0]            cnt_q, cnt_d;
    logic                  we_q, we_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [NUM_CORES-1:0]  rsp_valid_q, rsp_valid_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0]     rsp_rdata_q, rsp_rdata_d;

    logic [NUM_CORES-1:0]  gnt;
    logic [ID_W-1:0]       gnt_idx;
    logic                  gnt_valid;
    logic                  handshake;

    logic [ID_W-1:0]       cur_id;
    logic                  cur_we;
    logic [ADDR_W-1:0]     cur_addr;
    logic [DATA_W-1:0]     cur_wdata;
    logic                  in_range;
    logic                  entering_resp;
    logic                  mem_we;

    logic [DATA_W-1:0]     mem [DEPTH];

    mp_rr_arbiter #(.N(NUM_CORES)) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr_q),
        .enable    (state_q == IDLE),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    assign req_ready = gnt;
    assign handshake = (state_q == IDLE) && gnt_valid;

    // With LATENCY==0 the response edge is the handshake edge, so the live
    // request must be used instead of the not-yet-captured copy.
    always_comb begin
        if (state_q == IDLE) begin
            cur_id    = gnt_idx;
            cur_we    = req_we[gnt_idx];
            cur_addr  = req_addr[gnt_idx*ADDR_W +: ADDR_W];
            cur_wdata = req_wdata[gnt_idx*DATA_W +: DATA_W];
        end else begin
            cur_id    = id_q;
            cur_we    = we_q;
            cur_addr  = addr_q;
            cur_wdata = wdata_q;
        end
        in_range = 32'(cur_addr) < 32'(DEPTH);
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;
        id_d     = id_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        case (state_q)
            IDLE: begin
                if (handshake) begin
                    id_d     = gnt_idx;
                    we_d     = cur_we;
                    addr_d   = cur_addr;
                    wdata_d  = cur_wdata;
                    rr_ptr_d = (32'(gnt_idx) == 32'(NUM_CORES - 1)) ? '0 : gnt_idx + 1'b1;
                    if (LATENCY == 0) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = 3'(LATENCY);
                    end
                end
            end
            WAIT: begin
                if (cnt_q <= 3'd1) begin
                    state_d = RESP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Response fields and the memory write are all registered on the edge
    // that enters RESP; out-of-range accesses report an error and touch nothing.
    always_comb begin
        entering_resp = (state_d == RESP) && (state_q != RESP);
        rsp_valid_d   = '0;
        rsp_err_d     = rsp_err_q;
        rsp_rdata_d   = rsp_rdata_q;
        if (entering_resp) begin
            rsp_valid_d = NUM_CORES'(1) << cur_id;
            rsp_err_d   = !in_range;
            rsp_rdata_d = (!cur_we && in_range) ? mem[cur_addr] : '0;
        end
        mem_we = entering_resp && cur_we && in_range && rst_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            cnt_q       <= '0;
            id_q        <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= '0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            cnt_q       <= cnt_d;
            id_q        <= id_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[cur_addr] <= cur_wdata;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign busy      = (state_q != IDLE);

endmodule
